// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, R-type funct codes, field positions.
// Imported by the instruction encoder and by the ALU-control decoder.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SRAV = 6'b000111;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_WRITE,
        S_FULL,
        S_ERR
    } enc_state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_instr_encoder_if.sv
// Request handshake + instruction-memory write bus of the encoder.
// master: request source / memory side; slave: the encoder.
interface alu_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic              req_var;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [4:0]        req_shamt;
    logic              clear;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_written;
    logic              full;
    logic              err;
    logic              chk_fail;

    modport master (
        output req_valid, req_op, req_var,
        output req_rs, req_rt, req_rd, req_shamt,
        output clear,
        input  req_ready, imem_we, imem_addr,
        input  imem_wdata, words_written,
        input  full, err, chk_fail
    );

    modport slave (
        input  req_valid, req_op, req_var,
        input  req_rs, req_rt, req_rd, req_shamt,
        input  clear,
        output req_ready, imem_we, imem_addr,
        output imem_wdata, words_written,
        output full, err, chk_fail
    );

endinterface

// File: rtl/alu_ctrl_decoder.sv
// ALU-control decoder: R-type funct back to the ALU op code.
// Ports: i_funct in; o_op, o_valid out.
module alu_ctrl_decoder
    import alu_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_op,
    output logic       o_valid
);

    always_comb begin
        o_op    = '0;
        o_valid = 1'b1;
        unique case (i_funct)
            F_AND:          o_op = OP_AND;
            F_OR:           o_op = OP_OR;
            F_XOR:          o_op = OP_XOR;
            F_NOR:          o_op = OP_NOR;
            F_ADD:          o_op = OP_ADD;
            F_SUB:          o_op = OP_SUB;
            F_SLTU:         o_op = OP_SLTU;
            F_SLT:          o_op = OP_SLT;
            F_SLL, F_SLLV:  o_op = OP_SLL;
            F_SRL, F_SRLV:  o_op = OP_SRL;
            F_SRA, F_SRAV:  o_op = OP_SRA;
            default:        o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_funct_encoder.sv
// Maps an ALU op (+ variable-shift select) to the R-type funct field.
// Ports: i_op, i_var in; o_funct, o_supported out.
module alu_funct_encoder
    import alu_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic       i_var,
    output logic [5:0] o_funct,
    output logic       o_supported
);

    always_comb begin
        o_funct     = '0;
        o_supported = 1'b1;
        unique case (i_op)
            OP_AND:  o_funct = F_AND;
            OP_OR:   o_funct = F_OR;
            OP_XOR:  o_funct = F_XOR;
            OP_NOR:  o_funct = F_NOR;
            OP_ADD:  o_funct = F_ADD;
            OP_SUB:  o_funct = F_SUB;
            OP_SLTU: o_funct = F_SLTU;
            OP_SLT:  o_funct = F_SLT;
            OP_SLL:  o_funct = i_var ? F_SLLV : F_SLL;
            OP_SRL:  o_funct = i_var ? F_SRLV : F_SRL;
            OP_SRA:  o_funct = i_var ? F_SRAV : F_SRA;
            default: o_supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_instr_encoder.sv
// Builds MIPS R-type words from ALU requests and streams them into imem.
// Ports: clk, rst (async, active high); bus = request + imem write side.
// Optional: ENC_ROUNDTRIP_CHECK_EN adds a funct->op decoder self-check
// driving the sticky chk_fail flag; otherwise chk_fail is tied low.
module alu_instr_encoder
    import alu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    alu_instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] L_BASE  = ADDR_W'(BASE_ADDR);

    enc_state_e        r_state;
    enc_state_e        w_next;
    logic [3:0]        r_op;
    logic              r_var;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [4:0]        r_shamt;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;

    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_shift;
    logic [5:0]        w_funct;
    logic              w_sup;
    logic [4:0]        w_rs_f;
    logic [4:0]        w_sh_f;
    logic [31:0]       w_word;

    // rst is folded in so ready reads 0 while reset is held
    assign w_ready  = (r_state == S_IDLE) && !bus.clear && !rst;
    assign w_accept = bus.req_valid && w_ready;
    assign w_last   = (r_count + 1'b1) == L_DEPTH;
    assign w_shift  = is_shift(r_op);

    alu_funct_encoder u_funct (
        .i_op        (r_op),
        .i_var       (r_var),
        .o_funct     (w_funct),
        .o_supported (w_sup)
    );

    // fixed shifts drop rs, everything else drops shamt
    always_comb begin
        w_rs_f = (w_shift && !r_var) ? 5'd0 : r_rs;
        w_sh_f = (w_shift && !r_var) ? r_shamt : 5'd0;
        w_word = '0;
        w_word[RS_LSB +: 5] = w_rs_f;
        w_word[RT_LSB +: 5] = r_rt;
        w_word[RD_LSB +: 5] = r_rd;
        w_word[SH_LSB +: 5] = w_sh_f;
        w_word[FN_LSB +: 6] = w_funct;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ENC;
            S_ENC:   w_next = w_sup ? S_WRITE : S_ERR;
            S_WRITE: w_next = w_last ? S_FULL : S_IDLE;
            S_ERR:   w_next = S_IDLE;
            S_FULL:  w_next = S_FULL;
            default: w_next = S_IDLE;
        endcase
        if (bus.clear) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_var   <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_shamt <= '0;
            r_wdata <= '0;
            r_addr  <= L_BASE;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= bus.req_op;
                r_var   <= bus.req_var;
                r_rs    <= bus.req_rs;
                r_rt    <= bus.req_rt;
                r_rd    <= bus.req_rd;
                r_shamt <= bus.req_shamt;
            end
            if (r_state == S_ENC && !bus.clear) begin
                r_wdata <= w_word;
            end
            if (bus.clear) begin
                r_addr  <= L_BASE;
                r_count <= '0;
            end else if (r_state == S_WRITE) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count + 1'b1;
            end
        end
    end

    // clear in the WRITE cycle cancels the strobe
    assign bus.imem_we       = (r_state == S_WRITE) && !bus.clear;
    assign bus.req_ready     = w_ready;
    assign bus.imem_addr     = r_addr;
    assign bus.imem_wdata    = r_wdata;
    assign bus.words_written = r_count;
    assign bus.full          = (r_state == S_FULL);
    assign bus.err           = (r_state == S_ERR);

`ifdef ENC_ROUNDTRIP_CHECK_EN
    logic [3:0] w_dec_op;
    logic       w_dec_ok;
    logic       r_chk_fail;

    alu_ctrl_decoder u_dec (
        .i_funct (w_funct),
        .o_op    (w_dec_op),
        .o_valid (w_dec_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_fail <= 1'b0;
        end else if (bus.clear) begin
            r_chk_fail <= 1'b0;
        end else if (r_state == S_ENC && w_sup &&
                     (!w_dec_ok || w_dec_op != r_op)) begin
            r_chk_fail <= 1'b1;
        end
    end

    assign bus.chk_fail = r_chk_fail;
`else
    assign bus.chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed bench for alu_instr_encoder with a cycle-level reference model.
// Model tracks pending request, word count and full flag from the rules.
module tb_alu_instr_encoder;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int BASE  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_instr_encoder_if #(.ADDR_W(AW)) bus ();

    alu_instr_encoder #(
        .ADDR_W    (AW),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // spec funct table: {supported, funct}
    function automatic logic [6:0] f_funct(input int op, input bit v);
        case (op)
            0:  return {1'b1, 6'h24};
            1:  return {1'b1, 6'h25};
            3:  return {1'b1, 6'h26};
            4:  return {1'b1, 6'h27};
            5:  return {1'b1, 6'h20};
            6:  return {1'b1, 6'h22};
            7:  return {1'b1, 6'h2b};
            8:  return {1'b1, 6'h2a};
            9:  return {1'b1, v ? 6'h04 : 6'h00};
            10: return {1'b1, v ? 6'h06 : 6'h02};
            11: return {1'b1, v ? 6'h07 : 6'h03};
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_word(input int op, input bit v,
        input int rs, input int rt, input int rd, input int sh);
        bit   shf;
        int   rs_e;
        int   sh_e;
        logic [6:0] fs;
        shf  = (op >= 9 && op <= 11);
        rs_e = (shf && !v) ? 0 : rs;
        sh_e = (shf && !v) ? sh : 0;
        fs   = f_funct(op, v);
        return 32'(rs_e * (1 << 21) + rt * (1 << 16) + rd * (1 << 11)
                   + sh_e * (1 << 6) + int'(fs[5:0]));
    endfunction

    // reference model state
    int          cyc;
    bit          m_pend;
    bit          m_wr;
    bit          m_full;
    int          m_pcyc;
    int          m_count;
    logic [31:0] m_word;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc     = 0;
            m_pend  = 0;
            m_wr    = 0;
            m_full  = 0;
            m_pcyc  = 0;
            m_count = 0;
            m_word  = '0;
        end else begin
            if (bus.clear) begin
                m_pend  = 0;
                m_full  = 0;
                m_count = 0;
            end else if (m_pend && cyc == m_pcyc) begin
                m_pend = 0;
                if (m_wr) begin
                    m_count++;
                    if (m_count == DEPTH) m_full = 1;
                end
            end else if (!m_pend && !m_full && bus.req_valid) begin
                logic [6:0] fs;
                fs     = f_funct(int'(bus.req_op), bus.req_var);
                m_pend = 1;
                m_pcyc = cyc + 2;
                m_wr   = fs[6];
                m_word = f_word(int'(bus.req_op), bus.req_var,
                                int'(bus.req_rs), int'(bus.req_rt),
                                int'(bus.req_rd), int'(bus.req_shamt));
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit ev;
            bit e_we;
            ev   = m_pend && (m_pcyc == cyc);
            e_we = ev && m_wr && !bus.clear;
            chk("ready", 32'(bus.req_ready),
                32'(!m_pend && !m_full && !bus.clear));
            chk("we", 32'(bus.imem_we), 32'(e_we));
            chk("err", 32'(bus.err), 32'(ev && !m_wr));
            chk("addr", 32'(bus.imem_addr), 32'((BASE + m_count) % 256));
            chk("count", 32'(bus.words_written), 32'(m_count));
            chk("full", 32'(bus.full), 32'(m_full));
            chk("chk_fail", 32'(bus.chk_fail), 32'd0);
            if (e_we) chk("wdata", bus.imem_wdata, m_word);
        end
    end

    task automatic send(input int op, input bit v, input int rs,
                        input int rt, input int rd, input int sh);
        bit got;
        got = 0;
        @(posedge clk); #1;
        bus.req_op    = 4'(op);
        bus.req_var   = v;
        bus.req_rs    = 5'(rs);
        bus.req_rt    = 5'(rt);
        bus.req_rd    = 5'(rd);
        bus.req_shamt = 5'(sh);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] d, output logic [7:0] a,
                            output bit we, output bit er);
        we = 0;
        er = 0;
        d  = '0;
        a  = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.imem_we) begin
                we = 1;
                d  = bus.imem_wdata;
                a  = bus.imem_addr;
                break;
            end
            if (bus.err) begin
                er = 1;
                break;
            end
        end
    endtask

    logic [31:0] d;
    logic [7:0]  a;
    bit          we;
    bit          er;

    initial begin
        bus.req_valid = 0;
        bus.req_op    = '0;
        bus.req_var   = 0;
        bus.req_rs    = '0;
        bus.req_rt    = '0;
        bus.req_rd    = '0;
        bus.req_shamt = '0;
        bus.clear     = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'(BASE));
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_count", 32'(bus.words_written), 32'd0);
        @(posedge clk); #1;
        rst = 0;

        send(5, 0, 1, 2, 3, 7);
        wait_out(d, a, we, er);
        chk("add_we", 32'(we), 32'd1);
        chk("add_word", d, 32'h00221820);
        chk("add_addr", 32'(a), 32'd0);

        send(9, 0, 7, 5, 4, 2);
        wait_out(d, a, we, er);
        chk("sll_word", d, 32'h00052080);
        chk("sll_addr", 32'(a), 32'd1);

        send(11, 1, 10, 9, 8, 3);
        wait_out(d, a, we, er);
        chk("srav_word", d, 32'h01494007);
        chk("srav_addr", 32'(a), 32'd2);

        send(2, 0, 1, 1, 1, 1);
        wait_out(d, a, we, er);
        chk("bad_op_err", 32'(er), 32'd1);
        chk("bad_op_we", 32'(we), 32'd0);
        @(negedge clk);
        chk("bad_op_count", 32'(bus.words_written), 32'd3);
        chk("bad_op_ready", 32'(bus.req_ready), 32'd1);

        send(4, 0, 2, 3, 4, 0);
        wait_out(d, a, we, er);
        chk("nor_addr", 32'(a), 32'd3);
        @(negedge clk);
        chk("full_set", 32'(bus.full), 32'd1);
        chk("full_count", 32'(bus.words_written), 32'd4);

        @(posedge clk); #1;
        bus.req_op    = 4'd6;
        bus.req_var   = 0;
        bus.req_rs    = 5'd3;
        bus.req_rt    = 5'd4;
        bus.req_rd    = 5'd5;
        bus.req_shamt = 5'd9;
        bus.req_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("full_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.clear = 1;
        @(negedge clk);
        chk("clear_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.clear = 0;
        @(negedge clk);
        chk("clear_count", 32'(bus.words_written), 32'd0);
        chk("clear_addr", 32'(bus.imem_addr), 32'(BASE));
        chk("clear_full", 32'(bus.full), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 0;
        wait_out(d, a, we, er);
        chk("sub_word", d, 32'h00642822);
        chk("sub_addr", 32'(a), 32'd0);

        send(1, 0, 6, 7, 8, 1);
        @(posedge clk); #1;
        bus.clear = 1;
        @(posedge clk); #1;
        bus.clear = 0;
        wait_out(d, a, we, er);
        chk("abort_no_we", 32'(we), 32'd0);
        chk("abort_count", 32'(bus.words_written), 32'd0);

        for (int op = 0; op < 16; op++) begin
            if (bus.full) begin
                @(posedge clk); #1;
                bus.clear = 1;
                @(posedge clk); #1;
                bus.clear = 0;
            end
            send(op, op[0], int'($urandom_range(31)),
                 int'($urandom_range(31)), int'($urandom_range(31)),
                 int'($urandom_range(31)));
            wait_out(d, a, we, er);
            chk("sweep_outcome", 32'(we),
                32'(!(op == 2 || op >= 12)));
            @(negedge clk);
        end

        @(posedge clk); #1;
        bus.clear = 1;
        @(posedge clk); #1;
        bus.clear = 0;
        send(5, 0, 1, 2, 3, 0);
        wait_out(d, a, we, er);
        chk("pre_rst_we", 32'(we), 32'd1);
        #1 rst = 1;
        #1;
        chk("mid_rst_we", 32'(bus.imem_we), 32'd0);
        chk("mid_rst_wdata", bus.imem_wdata, 32'd0);
        chk("mid_rst_addr", 32'(bus.imem_addr), 32'(BASE));
        chk("mid_rst_count", 32'(bus.words_written), 32'd0);
        chk("mid_rst_full", 32'(bus.full), 32'd0);
        chk("mid_rst_err", 32'(bus.err), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_instr_encoder.md
Name: alu_instr_encoder

Overview:
- Inverse of the ALU-control decoder: takes an ALU operation code plus register fields and builds the 32-bit MIPS R-type instruction word, including the funct field.
- Writes each built word sequentially into the instruction-memory write port, for test-program loading and self-test of the monocycle processor.
- Uses a valid/ready request handshake, a 5-state FSM, an address counter and a full/clear mechanism.

Parameters:
- ADDR_W, 8, instruction-memory word-address width
- DEPTH, 256, number of words the encoder may write; must be ≤ 2^ADDR_W and ≥ 1
- BASE_ADDR, 0, first word address after reset or clear

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  encoder accepts request this cycle
- req_op  in  4  ALU op code (AND=0000 OR=0001 XOR=0011 NOR=0100 ADD=0101 SUB=0110 SLTU=0111 SLT=1000 SLL=1001 SRL=1010 SRA=1011)
- req_var  in  1  shifts only: 1 selects the variable form (sllv/srlv/srav)
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_shamt  in  5  shift amount
- clear  in  1  synchronous restart of the address counter
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- words_written  out  ADDR_W+1  count of words written since reset or clear
- full  out  1  DEPTH words written
- err  out  1  one-cycle pulse for an unsupported op
- chk_fail  out  1  sticky round-trip mismatch flag (see Optional Feature)

Behaviour:
- Reset (async, immediate) sets all outputs to 0, imem_addr to BASE_ADDR and state to IDLE.
- FSM states: IDLE, ENC, WRITE, FULL, ERR.
- req_ready = (state==IDLE) && !clear. A request is accepted on the rising edge where valid && ready.
- IDLE: on accept, register the fields and go to ENC.
- ENC: encode into imem_wdata. Go to WRITE if the op is supported, otherwise go to ERR.
- WRITE: imem_we=1 for exactly one cycle. Then:
  - imem_addr increments;
  - words_written increments;
  - go to FULL if words_written reaches DEPTH, otherwise go to IDLE.
- ERR: err=1 for one cycle. No write, no address or count change. Return to IDLE.
- FULL: full=1 and req_ready=0. Stay until clear.
- Latency: accept at edge N gives imem_we high in cycle N+2. Peak throughput is 1 word per 3 cycles.
- Word format: [31:26]=000000, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=shamt, [5:0]=funct.
- Funct map:
  - ADD=100000, SUB=100010, AND=100100, OR=100101, XOR=100110, NOR=100111, SLT=101010, SLTU=101011;
  - SLL=000000 or 000100 when var; SRL=000010 or 000110 when var; SRA=000011 or 000111 when var.
- Field forcing:
  - non-shift ops: shamt=0 and req_var ignored;
  - fixed shifts: rs=0;
  - variable shifts: shamt=0.
- Unsupported ops: 0010 and 1100–1111.
- Address counter: imem_addr = BASE_ADDR + words_written, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
- clear, any state: aborts any pending ENC/WRITE with no strobe. Sets imem_addr=BASE_ADDR, words_written=0, full=0 and state=IDLE on the next edge.
- clear together with req_valid: clear wins and the request is not accepted.
- rst during WRITE: imem_we deasserts immediately.

Optional Feature:
- Macro ENC_ROUNDTRIP_CHECK_EN.
- When defined:
  - the produced funct is fed through an instance of the team's ALU-control decoder;
  - in the ENC state, a mismatch against the registered req_op sets chk_fail;
  - chk_fail stays set until rst or clear.
- When not defined: chk_fail is tied to 0, and no decoder is instantiated.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit ALU op constants;
  - the 6-bit funct constants;
  - the R-type field bit positions.
- Both this block and the ALU-control decoder import alu_pkg.
- One natural combinational sub-module, alu_funct_encoder:
  - inputs: op, var;
  - outputs: funct, supported.

Test Plan:
- ADD rs=1 rt=2 rd=3, shamt=7 -> imem_wdata=0x00221820 (shamt forced 0), imem_we at N+2, addr=0.
- SLL rt=5 rd=4 shamt=2, rs=7, var=0 -> 0x00052080 (rs forced 0); next addr=1.
- SRA var=1 rs=10 rt=9 rd=8 shamt=3 -> 0x01494007 (shamt forced 0).
- op=0010 -> err pulses 1 cycle, no imem_we, words_written unchanged, req_ready returns to 1.
- DEPTH=4: four writes -> full=1, req_ready=0 while a 5th req_valid is held; assert clear -> addr=0, words_written=0, then the 5th request writes at addr 0.
- rst asserted mid-WRITE -> imem_we drops in the same cycle, all outputs 0, addr=BASE_ADDR. With ENC_ROUNDTRIP_CHECK_EN, all supported ops leave chk_fail=0.
